mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 30 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester byte-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 17;
  localparam int MEM_DEPTH_DEF = 66564;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between core and dma requests.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result only when it can grant.
//
// Ports:
//   core_req, dma_req : pending requests
//   last_owner        : requester granted most recently (0=core, 1=dma)
//   grant_valid       : at least one request pending
//   winner            : selected requester (0=core, 1=dma)
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic core_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic winner
);

  always_comb begin
    grant_valid = core_req | dma_req;
    // On a tie, the requester that did not win last time goes next.
    if (core_req && dma_req) begin
      winner = (last_owner == CORE) ? DMA : CORE;
    end else begin
      winner = dma_req ? DMA : CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core and a dma requester onto one single-port byte RAM.
// Latency: req in IDLE cycle 0 -> mem_en cycle 1 -> ack cycle 2 -> IDLE cycle 3.
// Backpressure: requests are held until ack; requests seen outside IDLE are ignored.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   core_* / dma_*                   : req/we/addr/wdata in, ack/rdata/err out
//   mem_en/mem_we/mem_addr/mem_wdata : registered RAM port, mem_rdata back
//   busy, owner                      : transaction in flight, its owner (0=core, 1=dma)
//   core_grants, dma_grants          : grant counters, built only with MEM_ARB_STATS_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic              core_ack,
  output logic [7:0]        core_rdata,
  output logic              core_err,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              dma_err,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,

  output logic              busy,
  output logic              owner,
  output logic [15:0]       core_grants,
  output logic [15:0]       dma_grants
);

  state_e            state;
  logic              last_owner;
  logic              lat_we;
  logic              lat_err;

  logic              grant_valid;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;
  logic              sel_in_range;

  mem_arb_rr u_rr (
    .core_req    (core_req),
    .dma_req     (dma_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  always_comb begin
    sel_we       = (winner == DMA) ? dma_we    : core_we;
    sel_addr     = (winner == DMA) ? dma_addr  : core_addr;
    sel_wdata    = (winner == DMA) ? dma_wdata : core_wdata;
    sel_in_range = (32'(sel_addr) < 32'(MEM_DEPTH));
  end

  // mem_addr/mem_wdata double as the latched request fields; mem_en and
  // mem_we are only raised for in-range accesses so a bad address never
  // touches the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      owner      <= CORE;
      last_owner <= DMA;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      dma_ack    <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            owner      <= winner;
            last_owner <= winner;
            lat_we     <= sel_we;
            lat_err    <= ~sel_in_range;
            mem_en     <= sel_in_range;
            mem_we     <= sel_we & sel_in_range;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
          end
        end
        ISSUE: begin
          state    <= RESP;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          core_ack <= (owner == CORE);
          core_err <= (owner == CORE) & lat_err;
          dma_ack  <= (owner == DMA);
          dma_err  <= (owner == DMA) & lat_err;
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          core_ack <= 1'b0;
          core_err <= 1'b0;
          dma_ack  <= 1'b0;
          dma_err  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM data arrives the cycle after mem_en, i.e. exactly in RESP while the
  // ack register is high, so it is steered straight through.
  always_comb begin
    core_rdata = (core_ack && !lat_we && !lat_err) ? mem_rdata : 8'h00;
    dma_rdata  = (dma_ack  && !lat_we && !lat_err) ? mem_rdata : 8'h00;
  end

`ifdef MEM_ARB_STATS_EN
  logic grant_fire;
  assign grant_fire = (state == IDLE) && grant_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_grants <= 16'h0000;
      dma_grants  <= 16'h0000;
    end else if (grant_fire) begin
      if (winner == CORE && core_grants != 16'hFFFF) core_grants <= core_grants + 16'h0001;
      if (winner == DMA  && dma_grants  != 16'hFFFF) dma_grants  <= dma_grants  + 16'h0001;
    end
  end
`else
  assign core_grants = 16'h0000;
  assign dma_grants  = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte RAM on the memory port.
// Latency: checks the 3-cycle request/issue/response sequence.
// Backpressure: requesters hold req until ack and drop it in the following cycle.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we, core_ack, core_err;
  logic [16:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        dma_req, dma_we, dma_ack, dma_err;
  logic [16:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, owner;
  logic [15:0] core_grants, dma_grants;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_ack    (core_ack),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ack     (dma_ack),
    .dma_rdata   (dma_rdata),
    .dma_err     (dma_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .owner       (owner),
    .core_grants (core_grants),
    .dma_grants  (dma_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte RAM: one-cycle read latency.
  logic [7:0] ram [0:66563];
  always @(posedge clk) begin
    if (mem_en && mem_addr < 17'd66564) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Event counters sampled mid-cycle.
  int mem_en_cnt   = 0;
  int core_ack_cnt = 0;
  always @(negedge clk) begin
    if (mem_en === 1'b1)   mem_en_cnt   <= mem_en_cnt + 1;
    if (core_ack === 1'b1) core_ack_cnt <= core_ack_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated 3-cycle transaction; leaves the bench in the following IDLE cycle.
  task automatic run_op(input bit use_dma, input bit we, input logic [16:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
    if (use_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd;
    end
    tick();
    tick();
    check({tag, "_ack"},   use_dma ? dma_ack   : core_ack,   64'd1);
    check({tag, "_rdata"}, use_dma ? dma_rdata : core_rdata, 64'(exp_rd));
    tick();
    core_req = 1'b0;
    dma_req  = 1'b0;
  endtask

  int ack_before;
  int en_before;

  initial begin
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    ram[5] = 8'hA7;
    ram[6] = 8'h5A;

    // Reset state
    #3;
    check("rst_ctrl", 64'({busy, owner, mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
    check("rst_resp", 64'({core_ack, core_err, core_rdata, dma_ack, dma_err, dma_rdata}), 64'd0);
    check("rst_cnt",  64'({core_grants, dma_grants}), 64'd0);
    tick();
    tick();
    rst = 1'b1;

    // Single core read of address 5
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'd5;
    check("rd_c0_busy", busy, 64'd0);
    tick();
    check("rd_c1_en",   64'({mem_en, mem_we, busy, owner}), 64'b1010);
    check("rd_c1_addr", mem_addr, 64'd5);
    tick();
    check("rd_c2_cack",  core_ack,   64'd1);
    check("rd_c2_rdata", core_rdata, 64'hA7);
    check("rd_c2_dack",  64'({dma_ack, dma_rdata, core_err, mem_en}), 64'd0);
    tick();
    core_req = 1'b0;
    check("rd_c3_idle", 64'({core_ack, busy}), 64'd0);

    // Both requesting from reset: strict alternation starting with core
    rst = 1'b0;
    tick();
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'd5;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 17'd6;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d_owner", k), 64'({mem_en, owner}), 64'({1'b1, k[0]}));
      check($sformatf("rr%0d_addr",  k), mem_addr, (k[0] ? 64'd6 : 64'd5));
      tick();
      check($sformatf("rr%0d_acks",  k), 64'({core_ack, dma_ack}), (k[0] ? 64'b01 : 64'b10));
      check($sformatf("rr%0d_rdata", k), (k[0] ? 64'(dma_rdata) : 64'(core_rdata)),
            (k[0] ? 64'h5A : 64'hA7));
      tick();
    end
    core_req = 1'b0;
    dma_req  = 1'b0;

    // Last valid address: dma write, core read back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'd66563; dma_wdata = 8'h3C;
    tick();
    check("wr_hi_en",   64'({mem_en, mem_we, owner}), 64'b111);
    check("wr_hi_addr", 64'({mem_addr, mem_wdata}), 64'({17'd66563, 8'h3C}));
    tick();
    check("wr_hi_resp", 64'({dma_ack, dma_err, dma_rdata}), 64'({1'b1, 1'b0, 8'h00}));
    tick();
    dma_req = 1'b0;
    run_op(1'b0, 1'b0, 17'd66563, 8'h00, 8'h3C, "rd_hi");

    // First out-of-range address: error, RAM untouched
    en_before = mem_en_cnt;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'd66564; dma_wdata = 8'hC3;
    tick();
    check("oor_c1_busy", 64'({busy, owner, mem_en, mem_we}), 64'b1100);
    tick();
    check("oor_resp", 64'({dma_ack, dma_err, dma_rdata, core_ack}), 64'({1'b1, 1'b1, 8'h00, 1'b0}));
    tick();
    dma_req = 1'b0;
    check("oor_no_en", 64'(mem_en_cnt - en_before), 64'd0);
    check("oor_err_clr", dma_err, 64'd0);

    // Reset asserted during ISSUE of a core read
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'd5;
    tick();
    check("abort_pre", mem_en, 64'd1);
    rst = 1'b0;
    #1;
    check("abort_ctrl", 64'({busy, owner, mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
    check("abort_resp", 64'({core_ack, core_err, core_rdata, dma_ack, dma_err, dma_rdata}), 64'd0);
    core_req = 1'b0;
    tick();
    tick();
    ack_before = core_ack_cnt;
    rst = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("abort_no_ack", 64'(core_ack_cnt - ack_before), 64'd0);
    run_op(1'b0, 1'b0, 17'd6, 8'h00, 8'h5A, "post_rst");

    // Grant statistics: 10 core reads then 4 dma writes after a fresh reset
    rst = 1'b0;
    #1;
    check("stat_rst", 64'({core_grants, dma_grants}), 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) run_op(1'b0, 1'b0, 17'd5, 8'h00, 8'hA7, $sformatf("st_c%0d", i));
    for (int i = 0; i < 4; i++)  run_op(1'b1, 1'b1, 17'(10 + i), 8'h11, 8'h00, $sformatf("st_d%0d", i));
`ifdef MEM_ARB_STATS_EN
    check("stat_core", core_grants, 64'd10);
    check("stat_dma",  dma_grants,  64'd4);
`else
    check("stat_core", core_grants, 64'd0);
    check("stat_dma",  dma_grants,  64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
